// File: rtl/timer_pkg.sv
// timer_pkg: definitions shared by prog_timer and its prescaler.
//   timer_state_t  : IDLE / RUN / PAUSE / EXPIRED
//   FREQ_W_DEF     : default width of the cycles-per-second value
//   PERIOD_W_DEF   : default width of the seconds count
package timer_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RUN     = 2'd1,
        PAUSE   = 2'd2,
        EXPIRED = 2'd3
    } timer_state_t;

    localparam int FREQ_W_DEF   = 16;
    localparam int PERIOD_W_DEF = 16;

endpackage

// File: rtl/prog_timer_tick_gen.sv
// tick_gen: one-second prescaler for prog_timer.
//   clk     : rising-edge clock
//   reset   : asynchronous active-low reset
//   clear   : synchronous clear of the cycle counter (highest priority)
//   en      : advance the cycle counter on this edge
//   freq_q  : cycles per second, never 0 (the owner substitutes 1)
//   tick    : high for the one enabled cycle that completes a second
module tick_gen #(
    parameter int FREQ_W = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              clear,
    input  logic              en,
    input  logic [FREQ_W-1:0] freq_q,
    output logic              tick
);

    localparam logic [FREQ_W-1:0] ONE = FREQ_W'(1);

    logic [FREQ_W-1:0] tick_cnt_q;
    logic [FREQ_W-1:0] tick_cnt_d;

    // The second completes on the enabled edge where the count reaches freq-1.
    assign tick = en && (tick_cnt_q == (freq_q - ONE));

    always_comb begin
        tick_cnt_d = tick_cnt_q;
        if (clear) begin
            tick_cnt_d = '0;
        end else if (en) begin
            tick_cnt_d = tick ? '0 : (tick_cnt_q + ONE);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            tick_cnt_q <= '0;
        end else begin
            tick_cnt_q <= tick_cnt_d;
        end
    end

endmodule

// File: rtl/prog_timer.sv
// prog_timer: programmable seconds timer with start/abort, pause, auto-reload.
//   clk          : rising-edge clock
//   reset        : asynchronous active-low reset
//   start        : (re)start; latches clk_freq, timer_period, reload_mode
//   abort        : return to idle, overrides start
//   enable       : count gate; low pauses without losing progress
//   reload_mode  : 1 = periodic, 0 = one-shot
//   clk_freq     : cycles per second (0 behaves as 1)
//   timer_period : seconds to count
//   done         : one-cycle pulse per expiry
//   busy         : RUN or PAUSE
//   paused       : PAUSE
//   expired      : sticky after a one-shot expiry
//   remaining    : whole seconds left
module prog_timer
    import timer_pkg::*;
#(
    parameter int FREQ_W   = FREQ_W_DEF,
    parameter int PERIOD_W = PERIOD_W_DEF
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                start,
    input  logic                abort,
    input  logic                enable,
    input  logic                reload_mode,
    input  logic [FREQ_W-1:0]   clk_freq,
    input  logic [PERIOD_W-1:0] timer_period,
    output logic                done,
    output logic                busy,
    output logic                paused,
    output logic                expired,
    output logic [PERIOD_W-1:0] remaining
);

    localparam logic [FREQ_W-1:0]   F_ONE = FREQ_W'(1);
    localparam logic [PERIOD_W-1:0] P_ONE = PERIOD_W'(1);

    timer_state_t        state_q, state_d;
    logic [FREQ_W-1:0]   freq_q, freq_d;
    logic [PERIOD_W-1:0] period_q, period_d;
    logic                reload_q, reload_d;
    logic [PERIOD_W-1:0] remaining_q, remaining_d;
    logic                done_q, done_d;
    logic                expired_q, expired_d;
    logic                busy_q, busy_d;
    logic                paused_q, paused_d;

    logic in_busy;
    logic zero_exp;
    logic tick_clear;
    logic tick;

    assign in_busy  = (state_q == RUN) || (state_q == PAUSE);
    // A zero-second period can only leave remaining at 0 while busy; it
    // expires on the very next edge regardless of enable.
    assign zero_exp = in_busy && (remaining_q == '0);
    assign tick_clear = abort || start || zero_exp;

    tick_gen #(
        .FREQ_W (FREQ_W)
    ) u_tick_gen (
        .clk    (clk),
        .reset  (reset),
        .clear  (tick_clear),
        .en     (in_busy && enable),
        .freq_q (freq_q),
        .tick   (tick)
    );

    always_comb begin
        state_d     = state_q;
        freq_d      = freq_q;
        period_d    = period_q;
        reload_d    = reload_q;
        remaining_d = remaining_q;
        done_d      = 1'b0;
        expired_d   = expired_q;

        if (abort) begin
            state_d     = IDLE;
            remaining_d = '0;
            expired_d   = 1'b0;
        end else if (start) begin
            // A start on an expiry edge lands here, so that expiry is dropped.
            freq_d      = (clk_freq == '0) ? F_ONE : clk_freq;
            period_d    = timer_period;
            reload_d    = reload_mode;
            remaining_d = timer_period;
            expired_d   = 1'b0;
            state_d     = enable ? RUN : PAUSE;
        end else if (in_busy) begin
            state_d = enable ? RUN : PAUSE;
            if (zero_exp) begin
                done_d    = 1'b1;
                state_d   = EXPIRED;
                expired_d = 1'b1;
            end else if (tick) begin
                if (remaining_q == P_ONE) begin
                    done_d = 1'b1;
                    if (reload_q) begin
                        remaining_d = period_q;
                    end else begin
                        remaining_d = '0;
                        state_d     = EXPIRED;
                        expired_d   = 1'b1;
                    end
                end else begin
                    remaining_d = remaining_q - P_ONE;
                end
            end
        end

        busy_d   = (state_d == RUN) || (state_d == PAUSE);
        paused_d = (state_d == PAUSE);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= IDLE;
            freq_q      <= '0;
            period_q    <= '0;
            reload_q    <= 1'b0;
            remaining_q <= '0;
            done_q      <= 1'b0;
            expired_q   <= 1'b0;
            busy_q      <= 1'b0;
            paused_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            freq_q      <= freq_d;
            period_q    <= period_d;
            reload_q    <= reload_d;
            remaining_q <= remaining_d;
            done_q      <= done_d;
            expired_q   <= expired_d;
            busy_q      <= busy_d;
            paused_q    <= paused_d;
        end
    end

    assign done      = done_q;
    assign busy      = busy_q;
    assign paused    = paused_q;
    assign expired   = expired_q;
    assign remaining = remaining_q;

endmodule

// File: tb/tb_prog_timer.sv
// Testbench for prog_timer: directed vector table, corner-case sequences,
// and randomized traffic compared against a behavioural model.
module tb_prog_timer;

    logic        clk = 1'b0;
    logic        reset;
    logic        start, abort, enable, reload_mode;
    logic [15:0] clk_freq, timer_period;
    logic        done, busy, paused, expired;
    logic [15:0] remaining;

    always #5 clk = ~clk;

    prog_timer #(.FREQ_W(16), .PERIOD_W(16)) dut (
        .clk          (clk),
        .reset        (reset),
        .start        (start),
        .abort        (abort),
        .enable       (enable),
        .reload_mode  (reload_mode),
        .clk_freq     (clk_freq),
        .timer_period (timer_period),
        .done         (done),
        .busy         (busy),
        .paused       (paused),
        .expired      (expired),
        .remaining    (remaining)
    );

    typedef struct {
        logic        st, ab, en, rl;
        logic [15:0] f, p;
        logic        d, b, pa, ex;
        logic [15:0] rem;
    } vec_t;

    vec_t vecs[$];
    int   checks = 0;
    int   errors = 0;

    // Behavioural model: progress is a count of enabled edges since start;
    // expiry happens when it reaches freq*period.
    bit          m_active, m_paused, m_expired, m_done, m_reload;
    int unsigned m_f, m_p, m_elapsed, m_rem;

    task automatic model_reset();
        m_active = 0; m_paused = 0; m_expired = 0; m_done = 0; m_reload = 0;
        m_f = 1; m_p = 0; m_elapsed = 0; m_rem = 0;
    endtask

    task automatic model_edge();
        if (abort) begin
            m_active = 0; m_paused = 0; m_expired = 0; m_done = 0;
            m_rem = 0; m_elapsed = 0;
        end else if (start) begin
            m_f = (clk_freq == 0) ? 1 : clk_freq;
            m_p = timer_period;
            m_reload = reload_mode;
            m_elapsed = 0;
            m_active = 1; m_paused = !enable; m_expired = 0; m_done = 0;
            m_rem = m_p;
        end else if (m_active) begin
            m_done = 0;
            m_paused = !enable;
            if (m_p == 0) begin
                m_done = 1; m_active = 0; m_paused = 0; m_expired = 1;
            end else if (enable) begin
                m_elapsed++;
                if (m_elapsed == m_f * m_p) begin
                    m_done = 1;
                    if (m_reload) begin
                        m_elapsed = 0; m_rem = m_p;
                    end else begin
                        m_active = 0; m_paused = 0; m_expired = 1; m_rem = 0;
                    end
                end else begin
                    m_rem = m_p - m_elapsed / m_f;
                end
            end
        end else begin
            m_done = 0;
        end
    endtask

    function automatic logic [19:0] dut_out();
        return {done, busy, paused, expired, remaining};
    endfunction

    function automatic logic [19:0] mdl_out();
        return {m_done, m_active, m_paused, m_expired, m_rem[15:0]};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    task automatic set_in(input logic st, input logic ab, input logic en, input logic rl,
                          input logic [15:0] f, input logic [15:0] p);
        start = st; abort = ab; enable = en; reload_mode = rl;
        clk_freq = f; timer_period = p;
    endtask

    // One clock edge: the model consumes the same inputs, outputs compared #1 later.
    task automatic step();
        @(posedge clk);
        if (reset) model_edge();
        #1;
        chk("model", 32'(dut_out()), 32'(mdl_out()));
    endtask

    task automatic add_vec(input logic st, input logic ab, input logic en, input logic rl,
                           input logic [15:0] f, input logic [15:0] p,
                           input logic d, input logic b, input logic pa, input logic ex,
                           input logic [15:0] rem);
        vec_t v;
        v.st = st; v.ab = ab; v.en = en; v.rl = rl; v.f = f; v.p = p;
        v.d = d; v.b = b; v.pa = pa; v.ex = ex; v.rem = rem;
        vecs.push_back(v);
    endtask

    initial begin
        logic [15:0] r;
        // 5 x 1 one-shot: done after edge 5
        add_vec(1,0,1,0, 5,1, 0,1,0,0, 1);
        for (int i = 1; i <= 4; i++) add_vec(0,0,1,0, 0,0, 0,1,0,0, 1);
        add_vec(0,0,1,0, 0,0, 1,0,0,1, 0);
        add_vec(0,0,1,0, 0,0, 0,0,0,1, 0);
        // zero period: done on next edge, then EXPIRED
        add_vec(1,0,1,0, 3,0, 0,1,0,0, 0);
        add_vec(0,0,1,0, 0,0, 1,0,0,1, 0);
        add_vec(0,0,1,0, 0,0, 0,0,0,1, 0);
        // abort + start together: idle, expired cleared
        add_vec(1,1,1,0, 3,4, 0,0,0,0, 0);
        add_vec(0,0,1,0, 0,0, 0,0,0,0, 0);
        // clk_freq 0 behaves as 1
        add_vec(1,0,1,0, 0,2, 0,1,0,0, 2);
        add_vec(0,0,1,0, 0,0, 0,1,0,0, 1);
        add_vec(0,0,1,0, 0,0, 1,0,0,1, 0);
        // start with enable low enters PAUSE
        add_vec(1,0,0,0, 2,1, 0,1,1,0, 1);
        add_vec(0,0,0,0, 0,0, 0,1,1,0, 1);
        add_vec(0,0,1,0, 0,0, 0,1,0,0, 1);
        add_vec(0,0,1,0, 0,0, 1,0,0,1, 0);
        // 4 x 3 with a 6-cycle pause after edge 5: done at edge 18
        add_vec(1,0,1,0, 4,3, 0,1,0,0, 3);
        for (int k = 1; k <= 5; k++) begin
            r = 16'(3 - k / 4);
            add_vec(0,0,1,0, 0,0, 0,1,0,0, r);
        end
        for (int k = 0; k < 6; k++) add_vec(0,0,0,0, 0,0, 0,1,1,0, 2);
        for (int c = 6; c <= 11; c++) begin
            r = 16'(3 - c / 4);
            add_vec(0,0,1,0, 0,0, 0,1,0,0, r);
        end
        add_vec(0,0,1,0, 0,0, 1,0,0,1, 0);

        // reset state
        reset = 1'b0;
        set_in(0,0,0,0, 0,0);
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        chk("reset_state", 32'(dut_out()), 32'h0);
        reset = 1'b1;

        foreach (vecs[i]) begin
            set_in(vecs[i].st, vecs[i].ab, vecs[i].en, vecs[i].rl, vecs[i].f, vecs[i].p);
            step();
            chk($sformatf("vec%0d", i), 32'(dut_out()),
                32'({vecs[i].d, vecs[i].b, vecs[i].pa, vecs[i].ex, vecs[i].rem}));
            $display("vec %0d st=%0b ab=%0b en=%0b f=%0d p=%0d -> done=%0b busy=%0b paused=%0b expired=%0b rem=%0d",
                     i, vecs[i].st, vecs[i].ab, vecs[i].en, vecs[i].f, vecs[i].p,
                     done, busy, paused, expired, remaining);
        end

        // reload 2 x 2: done at edges 4, 8, 12, remaining reloads, never expired
        set_in(1,0,1,1, 2,2);
        step();
        set_in(0,0,1,0, 0,0);
        for (int k = 1; k <= 13; k++) begin
            step();
            chk($sformatf("reload_done_e%0d", k), 32'(done), 32'((k % 4) == 0));
            chk($sformatf("reload_exp_e%0d", k), 32'(expired), 32'h0);
            if (k == 4) chk("reload_rem", 32'(remaining), 32'd2);
        end
        $display("seq reload: done pulses checked over 13 edges");

        // restart at edge 7 of a 5 x 2 run with period 1: done at edge 12 only
        set_in(1,0,1,0, 5,2);
        step();
        for (int k = 1; k <= 14; k++) begin
            if (k == 7) set_in(1,0,1,0, 5,1);
            else        set_in(0,0,1,0, 0,0);
            step();
            chk($sformatf("restart_done_e%0d", k), 32'(done), 32'(k == 12));
        end
        $display("seq restart: done edge checked");

        // abort at edge 3 of a 5 x 2 run
        set_in(1,0,1,0, 5,2);
        step();
        for (int k = 1; k <= 12; k++) begin
            if (k == 3) set_in(0,1,1,0, 0,0);
            else        set_in(0,0,1,0, 0,0);
            step();
            chk($sformatf("abort_done_e%0d", k), 32'(done), 32'h0);
            if (k == 3) chk("abort_state", 32'(dut_out()), 32'h0);
        end
        $display("seq abort: idle after abort, no done");

        // asynchronous reset mid-run
        set_in(1,0,1,0, 3,4);
        step();
        set_in(0,0,1,0, 0,0);
        repeat (4) step();
        reset = 1'b0;
        #1;
        chk("async_reset", 32'(dut_out()), 32'h0);
        model_reset();
        @(negedge clk);
        reset = 1'b1;
        $display("seq async reset: outputs cleared without a clock edge");

        // randomized traffic against the model
        for (int n = 0; n < 600; n++) begin
            set_in($urandom_range(0, 11) == 0, $urandom_range(0, 39) == 0,
                   $urandom_range(0, 4) != 0, 1'($urandom_range(0, 1)),
                   16'($urandom_range(0, 4)), 16'($urandom_range(0, 4)));
            if (start && !abort)
                $display("rand start n=%0d f=%0d p=%0d reload=%0b en=%0b",
                         n, clk_freq, timer_period, reload_mode, enable);
            step();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/prog_timer.md
# prog_timer

Parametrised programmable seconds timer for the washing-machine controller, the next generation of the basic `timer`. Divides `clk` by a programmable `clk_freq` to make a one-second tick, then counts `timer_period` seconds down. Adds explicit start/abort control, pause via `enable`, auto-reload mode, a remaining-seconds readout and a sticky expiry flag. The cycle controller uses one instance per wash/rinse/spin phase.

## Interface
- `FREQ_W`, 16: width of `clk_freq` (clock cycles per second).
- `PERIOD_W`, 16: width of `timer_period` and `remaining` (seconds).
- `clk`  in  1  rising-edge clock.
- `reset`  in  1  asynchronous, active-low reset.
- `start`  in  1  one-cycle start/restart request; samples `clk_freq`, `timer_period`, `reload_mode`.
- `abort`  in  1  stop and return to idle; priority over `start`.
- `enable`  in  1  count gate; low pauses counting without losing progress.
- `reload_mode`  in  1  1 = periodic (auto-reload), 0 = one-shot.
- `clk_freq`  in  FREQ_W  cycles per second; 0 is treated as 1.
- `timer_period`  in  PERIOD_W  seconds to count.
- `done`  out  1  one-cycle pulse at each expiry.
- `busy`  out  1  timer is RUN or PAUSE.
- `paused`  out  1  timer is in PAUSE.
- `expired`  out  1  sticky after one-shot expiry; cleared by `start`, `abort` or `reset`.
- `remaining`  out  PERIOD_W  whole seconds left.

## Operation
- States: IDLE, RUN, PAUSE, EXPIRED.
- `start` is accepted in any state, so a start while busy restarts the timer. On acceptance:
  - `freq_q`, `period_q` and `reload_q` latch.
  - `tick_cnt` clears to 0 and `remaining` loads `timer_period`.
  - `expired` clears and the state goes to RUN, or PAUSE if `enable`=0.
- RUN↔PAUSE: the next state follows `enable` on every edge while busy.
- Counting: on each edge where busy and `enable`=1, `tick_cnt` increments.
- Second tick: when `tick_cnt`=`freq_q`−1, `tick_cnt` wraps to 0 and `remaining` decrements.
- Expiry is the tick where `remaining`=1:
  - `done` pulses.
  - One-shot: `remaining` goes to 0, the state goes to EXPIRED and `expired` sets.
  - Reload: `remaining` reloads `period_q` and the state stays RUN/PAUSE; `expired` is not set.
- `timer_period`=0 at start: `done` pulses on the next edge and the timer enters EXPIRED, even if reload is set.
- `abort` → IDLE. `remaining`←0, `tick_cnt`←0, `expired` cleared, no `done`.
- Simultaneous events:
  - `abort`+`start`: abort wins.
  - `start` on an expiry edge: the restart wins and no `done` is produced.
- `enable` low on the expiry edge: no tick, so expiry is deferred.

## Timing
- Reset values: `done`=0, `busy`=0, `paused`=0, `expired`=0, `remaining`=0; state IDLE; `tick_cnt`=0.
- All outputs are registered.
- Latency: `done` is high in the cycle after the N-th enabled edge following the start edge, where N = `freq_q`×`period_q`.
- `remaining` updates in the cycle after its tick edge. `busy` goes high the cycle after start.
- `done` is exactly one cycle wide. In reload mode, pulses are spaced N enabled edges apart.
- An asserted `reset` mid-operation forces the reset values immediately (asynchronously). No pending `done` survives.
- `tick_cnt` is FREQ_W bits wide, compared against `freq_q`−1. No overflow is possible.

## Structure
- Package `timer_pkg`:
  - state enum `timer_state_t` (IDLE, RUN, PAUSE, EXPIRED);
  - default width localparams.
- Sub-module `tick_gen`: the prescaler, with inputs `clear`, `en` and `freq_q`, and a one-cycle `tick` output.
- `prog_timer`: FSM, latches, seconds counter and flags.

## Test plan
- `clk_freq`=5, `timer_period`=1, `enable`=1, start at edge 0 → `done` high in the cycle after edge 5; `expired`=1 afterwards; `busy`=0.
- `clk_freq`=4, `timer_period`=3, `enable` low for 6 cycles after edge 5 → `paused`=1 during the gap; `remaining` sequence 3,2,1,0; `done` at edge 18.
- Reload mode with `clk_freq`=2, `timer_period`=2 → `done` pulses at edges 4, 8, 12; `remaining` reloads to 2; `expired` stays 0.
- Abort at edge 3 of a 5×2 run → IDLE, `remaining`=0, no `done`. Abort+start in the same cycle → stays IDLE.
- Restart at edge 7 of a 5×2 run with new `timer_period`=1 → `done` at edge 12, not at edge 10.
- `reset` low mid-run → all outputs 0 immediately. `timer_period`=0 at start → single `done` at edge 1, then EXPIRED.
